// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU opcode constants and shift-add multiplier state encodings.
// Used by the ALU, its decoder and the sequential multiplier.
package alu_mul_seq_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SLL = 5'd5;
  localparam logic [4:0] OP_NOP = 5'd28;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADD   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 16x16 shift-add multiplier sequencing an external shared ALU.
// Fixed latency of 16 ADD/SHIFT pairs; all arithmetic goes through alu_out.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for start, ALU parked on NOP
// ADD      | conditionally accumulate mcand when mplier[0] is set
// SHIFT    | mcand <<= 1 through the ALU, mplier >>= 1, count step
// DONE     | one-cycle done pulse, product/ofl already published
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter logic [4:0] ADD_OP = OP_ADD,
  parameter logic [4:0] SLL_OP = OP_SLL,
  parameter logic [4:0] NOP_OP = OP_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ofl,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        alu_sign,
  input  logic [15:0] alu_out,
  input  logic        alu_ofl
);

  logic [1:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ofl_acc_q, ofl_acc_d;
  logic [15:0] product_q, product_d;
  logic        ofl_q, ofl_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    ofl_acc_d = ofl_acc_q;
    product_d = product_q;
    ofl_d     = ofl_q;
    alu_a     = 16'd0;
    alu_b     = 16'd0;
    alu_op    = NOP_OP;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d   = a;
          mplier_d  = b;
          acc_d     = 16'd0;
          ofl_acc_d = 1'b0;
          cnt_d     = 4'd0;
          state_d   = ST_ADD;
        end
      end
      ST_ADD: begin
        alu_op = ADD_OP;
        alu_a  = acc_q;
        alu_b  = mcand_q;
        if (mplier_q[0]) begin
          acc_d     = alu_out;
          ofl_acc_d = ofl_acc_q | alu_ofl;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        alu_op   = SLL_OP;
        alu_a    = mcand_q;
        alu_b    = 16'd1;
        mcand_d  = alu_out;
        mplier_d = {1'b0, mplier_q[15:1]};
        // A set bit shifted out of mcand matters only if higher multiplier bits remain.
        if (mcand_q[15] && (mplier_q[15:1] != 15'd0)) begin
          ofl_acc_d = 1'b1;
        end
        if (cnt_q == 4'd15) begin
          product_d = acc_q;
          ofl_d     = ofl_acc_d;
          state_d   = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= 16'd0;
      mcand_q   <= 16'd0;
      mplier_q  <= 16'd0;
      cnt_q     <= 4'd0;
      ofl_acc_q <= 1'b0;
      product_q <= 16'd0;
      ofl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      ofl_acc_q <= ofl_acc_d;
      product_q <= product_d;
      ofl_q     <= ofl_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign product  = product_q;
  assign ofl      = ofl_q;
  assign alu_sign = 1'b0;

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter ADD_OP, default 5'd0, ALU opcode used for accumulate steps.
REQ-002 SHALL have parameter SLL_OP, default 5'd5, ALU opcode used for multiplicand shift steps.
REQ-003 SHALL have parameter NOP_OP, default 5'd28, ALU opcode driven when idle.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a multiply; sampled only in IDLE.
REQ-007 a  input  16  multiplicand, captured on accepted start.
REQ-008 b  input  16  multiplier, captured on accepted start.
REQ-009 busy  output  1  high from the cycle after an accepted start through the DONE cycle inclusive.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 product  output  16  low 16 bits of unsigned a*b, held until next accepted start.
REQ-012 ofl  output  1  unsigned overflow, i.e. true product exceeds 16'hFFFF; held with product.
REQ-013 alu_a, alu_b  output  16 each  operands driven to the shared ALU.
REQ-014 alu_op  output  5  ALU opcode; alu_sign  output  1  constant 0 (unsigned).
REQ-015 alu_out  input  16  ALU result; alu_ofl  input  1  ALU overflow flag (combinational from alu_a/alu_b/alu_op).

Function
REQ-016 SHALL implement FSM states IDLE, ADD, SHIFT, DONE.
REQ-017 IDLE: alu_op=NOP_OP, alu_a=alu_b=0; start=1 captures a into mcand, b into mplier, clears acc, ofl, and the 4-bit bit counter, and moves to ADD.
REQ-018 ADD: alu_op=ADD_OP, alu_a=acc, alu_b=mcand; if mplier[0]=1, acc<=alu_out and sticky ofl|=alu_ofl, else acc unchanged; next state SHIFT.
REQ-019 SHIFT: alu_op=SLL_OP, alu_a=mcand, alu_b=16'd1; mcand<=alu_out; mplier<=mplier>>1; if mcand[15]=1 and (mplier>>1)!=0, ofl<=1.
REQ-020 SHIFT with bit counter 15 SHALL go to DONE; otherwise counter increments (mod-16 wrap not reached) and state returns to ADD.
REQ-021 Latency SHALL be fixed: start accepted at edge N, done high during cycle N+33 (16 ADD + 16 SHIFT cycles), independent of operand values; no early termination.
REQ-022 DONE: done=1, product<=acc, final ofl published, alu_op=NOP_OP; next state IDLE unconditionally.
REQ-023 product/ofl SHALL change only on the transition into DONE (or reset); stable otherwise.
REQ-024 start while busy (ADD, SHIFT, DONE) SHALL be ignored, not queued.
REQ-025 start asserted in the IDLE cycle following DONE SHALL be accepted (back-to-back throughput one result per 34 cycles).
REQ-026 a or b equal to zero SHALL still take full latency; product=0, ofl=0.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, product=0, ofl=0, done=0, busy=0, acc=mcand=mplier=0, counter=0, regardless of state.
REQ-028 Reset mid-operation SHALL abort with no done pulse; rst has priority over start in the same cycle.

Structure
REQ-029 ALU opcode constants (ADD, SLL, NOP) and the FSM state encodings SHALL live in the shared ALU opcode package/include used by the ALU and decoder.
REQ-030 The ALU is instantiated outside this block; the block SHALL contain no adder or shifter of its own and SHALL compute all arithmetic through alu_out.
REQ-031 No sub-module required; the 4-bit step counter stays inline.

Verification (bench instantiates alu_mul_seq with the real ALU)
REQ-032 start, a=3, b=5 -> done at cycle N+33, product=16'd15, ofl=0, busy high cycles N+1..N+33.
REQ-033 a=16'hFFFF, b=2 -> product=16'hFFFE, ofl=1; a=16'h0100, b=16'h0100 -> product=0, ofl=1.
REQ-034 a=0, b=16'hFFFF -> product=0, ofl=0, still 33-cycle latency; a=16'h00FF, b=16'h0101 -> product=16'hFFFF, ofl=0.
REQ-035 start pulsed at N and again at N+10 with different operands -> single done at N+33 with first result; start at N+34 accepted, done at N+67.
REQ-036 rst asserted at N+12 during operation -> next cycle IDLE, product=0, no done pulse; start+rst in same cycle -> remains IDLE.
